pipeline_if: RTL and testbench

//  Instruction fetch stage: owns the PC and issues fetch requests to instruction memory.

---
 rtl/pipeline_if.sv | 121 ++++++++++++
 tb/tb_pipeline_if.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_if.sv
// rtl/pipeline_if.sv - instruction fetch stage: PC ownership, single in-flight fetch, stall and redirect handling
module pipeline_if #(
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] pend_pc, pend_pc_n;
  logic [INST_W-1:0] inst_n;
  logic [ADDR_W-1:0] inst_pc_n;
  logic              inst_valid_n;
  logic              mem_req_n;
  logic [ADDR_W-1:0] target;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign target   = redirect_pc & ~ADDR_W'(3);
  // The PC register drives the memory address directly, so it only moves
  // when no request is outstanding or when the request just completed.
  assign mem_addr = pc;

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RST_PC;
      pend_pc    <= '0;
      mem_req    <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_pc    <= pend_pc_n;
      mem_req    <= mem_req_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
    end
  end

  // Next-state and next-output logic; mem_req follows the next state so it is
  // high exactly while in FETCH or DISCARD.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_pc_n    = pend_pc;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid;
    case (state)
      IDLE: begin
        if (redirect) pc_n = target;
        state_n = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          if (redirect) begin
            // Returned word belongs to the squashed path; refetch at the target.
            pc_n    = target;
            state_n = FETCH;
          end else begin
            inst_n       = mem_rdata;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc + ADDR_W'(4);
            state_n      = DELIVER;
          end
        end else if (redirect) begin
          // Address must stay stable until the outstanding ack arrives.
          pend_pc_n = target;
          state_n   = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect) pend_pc_n = target;
        if (mem_ack) begin
          pc_n    = redirect ? target : pend_pc;
          state_n = FETCH;
        end
      end
      DELIVER: begin
        if (redirect) begin
          inst_valid_n = 1'b0;
          pc_n         = target;
          state_n      = FETCH;
        end else if (!stall) begin
          inst_valid_n = 1'b0;
          state_n      = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
    mem_req_n = (state_n == FETCH) || (state_n == DISCARD);
  end

endmodule

// File: tb/tb_pipeline_if.sv
// tb/tb_pipeline_if.sv - directed self-checking bench for pipeline_if
module tb_pipeline_if;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        mem_ack, mem_ack1;
  logic [31:0] mem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;

  logic        mem_req, mem_req1;
  logic [31:0] mem_addr, mem_addr1;
  logic [31:0] inst, inst1;
  logic [31:0] inst_pc, inst_pc1;
  logic        inst_valid, inst_valid1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipeline_if #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst),
    .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  pipeline_if #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst(rst1), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_ack(mem_ack1), .mem_rdata(mem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst1),
    .inst_pc(inst_pc1), .inst_valid(inst_valid1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; mem_ack = 1'b0; mem_ack1 = 1'b0;
    mem_rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // 1: idle cycle, fetch, deliver
    rst = 1'b0;
    check("idle_req", {31'd0, mem_req}, 32'd0);
    step();
    check("t1_req", {31'd0, mem_req}, 32'd1);
    check("t1_addr", mem_addr, 32'h0);
    step();
    check("t1_req_hold", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    step();
    mem_ack = 1'b0;
    check("t1_valid", {31'd0, inst_valid}, 32'd1);
    check("t1_inst", inst, 32'h00500093);
    check("t1_inst_pc", inst_pc, 32'h0);
    check("t1_req_deliver", {31'd0, mem_req}, 32'd0);

    // 2: stall holds DELIVER
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_valid", {31'd0, inst_valid}, 32'd1);
      check("t2_stall_inst", inst, 32'h00500093);
      check("t2_stall_inst_pc", inst_pc, 32'h0);
      check("t2_stall_req", {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("t2_rel_valid", {31'd0, inst_valid}, 32'd0);
    check("t2_rel_req", {31'd0, mem_req}, 32'd1);
    check("t2_rel_addr", mem_addr, 32'h4);

    // 3: redirect with fetch in flight, then redirects while discarding
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("t3_disc_addr", mem_addr, 32'h4);
    check("t3_disc_req", {31'd0, mem_req}, 32'd1);
    step();
    check("t3_disc_addr2", mem_addr, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check("t3_drop_valid", {31'd0, inst_valid}, 32'd0);
    check("t3_new_addr", mem_addr, 32'h100);
    check("t3_new_req", {31'd0, mem_req}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("t3_disc2_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t3_latest_addr", mem_addr, 32'h200);
    check("t3_latest_valid", {31'd0, inst_valid}, 32'd0);

    // 4: redirect together with ack, then redirect overriding a stall
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    mem_ack = 1'b0; redirect = 1'b0;
    check("t4_same_valid", {31'd0, inst_valid}, 32'd0);
    check("t4_same_addr", mem_addr, 32'h100);
    check("t4_same_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    check("t4_del_valid", {31'd0, inst_valid}, 32'd1);
    check("t4_del_inst_pc", inst_pc, 32'h100);
    check("t4_del_addr", mem_addr, 32'h104);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    stall = 1'b0; redirect = 1'b0;
    check("t4_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("t4_redir_addr", mem_addr, 32'h100);
    check("t4_redir_req", {31'd0, mem_req}, 32'd1);

    // 6: asynchronous reset mid-FETCH
    #3 rst = 1'b1;
    #1;
    check("t6_req", {31'd0, mem_req}, 32'd0);
    check("t6_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_addr", mem_addr, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("t6_refetch_req", {31'd0, mem_req}, 32'd1);
    check("t6_refetch_addr", mem_addr, 32'h0);

    // 5: PC wrap and redirect alignment on the second instance
    rst1 = 1'b0;
    step();
    check("t5_first_addr", mem_addr1, 32'hFFFFFFFC);
    check("t5_first_req", {31'd0, mem_req1}, 32'd1);
    mem_ack1 = 1'b1; mem_rdata = 32'h00000013;
    step();
    mem_ack1 = 1'b0;
    check("t5_inst_pc", inst_pc1, 32'hFFFFFFFC);
    check("t5_valid", {31'd0, inst_valid1}, 32'd1);
    step();
    check("t5_wrap_addr", mem_addr1, 32'h0);
    check("t5_wrap_req", {31'd0, mem_req1}, 32'd1);
    mem_ack1 = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    step();
    mem_ack1 = 1'b0; redirect = 1'b0;
    check("t5_align_addr", mem_addr1, 32'h100);
    check("t5_align_valid", {31'd0, inst_valid1}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
